// File: rtl/cpu_pkg.sv
// Shared definitions for the cpu instruction sequencer: opcode classes,
// sequencer states and the no-op instruction driven while idle.
package cpu_pkg;

    localparam logic [1:0] CLS_ALU  = 2'b00;
    localparam logic [1:0] CLS_MEM  = 2'b01;
    localparam logic [1:0] CLS_LDI  = 2'b10;
    localparam logic [1:0] CLS_HALT = 2'b11;

    localparam logic [7:0] IDLE_INSTR_DEF = 8'hC0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_ISSUE,
        ST_FINISH
    } seq_state_e;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/cpu_sequencer_prog_buffer.sv
// Program store: DEPTH x 8 words, one write port and one registered read port.
// A write to the address being read is forwarded so the next fetch sees it.
module prog_buffer #(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [7:0]    wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [7:0]    rdata_o
);

    logic [7:0] mem_q [DEPTH];
    logic [7:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (we_i && (waddr_i == raddr_i)) begin
            rdata_q <= wdata_i;
        end else begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/cpu_sequencer.sv
// Instruction sequencer: walks the program buffer and holds each instruction on
// the cpu userinput bus for a class-dependent number of cycles.
module cpu_sequencer
    import cpu_pkg::*;
#(
    parameter int         DEPTH      = 16,
    parameter int         CYC_LDI    = 2,
    parameter int         CYC_MEM    = 5,
    parameter int         CYC_ALU    = 4,
    parameter logic [7:0] IDLE_INSTR = IDLE_INSTR_DEF,
    localparam int        AW         = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          prog_we,
    input  logic [AW-1:0] prog_addr,
    input  logic [7:0]    prog_data,
    input  logic          start,
    input  logic          abort,
    output logic [7:0]    instr_out,
    output logic          instr_valid,
    output logic [AW-1:0] pc,
    output logic          busy,
    output logic          done,
    output logic          wr_err
);

    localparam int CW = $clog2(max3(CYC_LDI, CYC_MEM, CYC_ALU)) + 1;

    seq_state_e    state_q;
    logic [AW-1:0] pc_q;
    logic [CW-1:0] hold_q;
    logic [7:0]    instr_q;
    logic          valid_q;
    logic          busy_q;
    logic          done_q;
    logic          wr_err_q;

    logic [AW-1:0] rd_addr_d;
    logic [7:0]    rd_data;
    logic          buf_we;
    logic          in_run;

    // Remaining hold cycles after the first one, loaded on ISSUE entry.
    function automatic logic [CW-1:0] hold_load(input logic [1:0] cls);
        case (cls)
            CLS_LDI: hold_load = CW'(CYC_LDI - 1);
            CLS_MEM: hold_load = CW'(CYC_MEM - 1);
            default: hold_load = CW'(CYC_ALU - 1);
        endcase
    endfunction

    assign in_run = (state_q == ST_FETCH) || (state_q == ST_ISSUE);
    assign buf_we = prog_we && !in_run;

    // Read address runs one cycle ahead so the word is ready during FETCH.
    always_comb begin
        rd_addr_d = pc_q;
        if ((state_q == ST_ISSUE) && (hold_q == '0)) begin
            rd_addr_d = pc_q + 1'b1;
        end
    end

    prog_buffer #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_prog_buffer (
        .clk     (clk),
        .we_i    (buf_we),
        .waddr_i (prog_addr),
        .wdata_i (prog_data),
        .raddr_i (rd_addr_d),
        .rdata_o (rd_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            pc_q     <= '0;
            hold_q   <= '0;
            instr_q  <= IDLE_INSTR;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            wr_err_q <= 1'b0;
        end else begin
            done_q   <= 1'b0;
            wr_err_q <= prog_we && in_run;
            if (abort) begin
                state_q <= ST_IDLE;
                pc_q    <= '0;
                hold_q  <= '0;
                instr_q <= IDLE_INSTR;
                valid_q <= 1'b0;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (start) begin
                            state_q <= ST_FETCH;
                            busy_q  <= 1'b1;
                        end
                    end
                    ST_FETCH: begin
                        if (rd_data[7:6] == CLS_HALT) begin
                            state_q <= ST_FINISH;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ST_ISSUE;
                            instr_q <= rd_data;
                            valid_q <= 1'b1;
                            hold_q  <= hold_load(rd_data[7:6]);
                        end
                    end
                    ST_ISSUE: begin
                        if (hold_q == '0) begin
                            instr_q <= IDLE_INSTR;
                            valid_q <= 1'b0;
                            if (pc_q == AW'(DEPTH - 1)) begin
                                state_q <= ST_FINISH;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                            end else begin
                                state_q <= ST_FETCH;
                                pc_q    <= pc_q + 1'b1;
                            end
                        end else begin
                            hold_q <= hold_q - 1'b1;
                        end
                    end
                    ST_FINISH: begin
                        state_q <= ST_IDLE;
                        pc_q    <= '0;
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        pc_q    <= '0;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign instr_out   = instr_q;
    assign instr_valid = valid_q;
    assign pc          = pc_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign wr_err      = wr_err_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer with hand-computed expectations.
module tb_cpu_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       prog_we;
    logic [3:0] prog_addr;
    logic [7:0] prog_data;
    logic       start;
    logic       abort;
    logic [7:0] instr_out;
    logic       instr_valid;
    logic [3:0] pc;
    logic       busy;
    logic       done;
    logic       wr_err;

    int errors = 0;
    int checks = 0;

    logic [7:0] run_instr[$];
    int         run_len[$];
    logic [3:0] run_pc[$];
    int         done_idx;
    logic [3:0] pc_at_done;
    int         idle_bad;
    int         busy_bad;

    always #5 clk = ~clk;

    cpu_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .prog_we     (prog_we),
        .prog_addr   (prog_addr),
        .prog_data   (prog_data),
        .start       (start),
        .abort       (abort),
        .instr_out   (instr_out),
        .instr_valid (instr_valid),
        .pc          (pc),
        .busy        (busy),
        .done        (done),
        .wr_err      (wr_err)
    );

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [3:0] a, input logic [7:0] d);
        prog_we = 1'b1; prog_addr = a; prog_data = d;
        cyc();
        prog_we = 1'b0;
    endtask

    task automatic wait_valid(input string tag, input int budget);
        int got;
        got = 0;
        for (int i = 0; i < budget; i++) begin
            if (instr_valid) begin got = 1; break; end
            cyc();
        end
        chk(tag, got, 1);
    endtask

    task automatic wait_done(input string tag, input int budget);
        int got;
        got = 0;
        for (int i = 0; i < budget; i++) begin
            if (done) begin got = 1; break; end
            cyc();
        end
        chk(tag, got, 1);
    endtask

    // Pulses start (any pending prog_we is released with it) and records each
    // valid run; idx 0 is the first sample after the start edge.
    task automatic watch(input string tag, input int budget);
        logic pv;
        int   got;
        pv = 1'b0; got = 0; done_idx = -1; pc_at_done = 4'hx;
        idle_bad = 0; busy_bad = 0;
        run_instr.delete(); run_len.delete(); run_pc.delete();
        start = 1'b1;
        cyc();
        start = 1'b0; prog_we = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (instr_valid) begin
                if (!pv) begin
                    run_instr.push_back(instr_out);
                    run_len.push_back(1);
                    run_pc.push_back(pc);
                end else begin
                    run_len[run_len.size()-1]++;
                end
            end else if (instr_out !== 8'hC0) begin
                idle_bad++;
            end
            pv = instr_valid;
            if (done) begin
                got = 1; done_idx = i; pc_at_done = pc;
                break;
            end
            if (!busy) busy_bad++;
            cyc();
        end
        chk({tag, "_done_seen"}, got, 1);
        chk({tag, "_idle_instr"}, idle_bad, 0);
        chk({tag, "_busy_run"}, busy_bad, 0);
        if (got == 1) begin
            cyc();
            chk({tag, "_done_width"}, done, 1'b0);
            chk({tag, "_pc_after"}, pc, 4'd0);
            chk({tag, "_busy_after"}, busy, 1'b0);
        end
    endtask

    initial begin
        int bad;
        logic [7:0] exp2 [4];
        int seen;
        exp2[0] = 8'h80; exp2[1] = 8'h91; exp2[2] = 8'hA2; exp2[3] = 8'hB3;

        rst = 1'b1; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
        start = 1'b0; abort = 1'b0;
        repeat (2) cyc();
        chk("rst_instr", instr_out, 8'hC0);
        chk("rst_valid", instr_valid, 1'b0);
        chk("rst_pc", pc, 4'd0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_wrerr", wr_err, 1'b0);
        rst = 1'b0;
        cyc();

        // Asynchronous reset in the middle of an issue; program is kept.
        load(4'd0, 8'h91);
        load(4'd1, 8'hFF);
        chk("idle_write_no_err", wr_err, 1'b0);
        start = 1'b1; cyc(); start = 1'b0;
        wait_valid("t1_valid_wait", 10);
        chk("t1_issue_instr", instr_out, 8'h91);
        cyc();
        #2 rst = 1'b1;
        #1;
        chk("t1_async_instr", instr_out, 8'hC0);
        chk("t1_async_valid", instr_valid, 1'b0);
        chk("t1_async_pc", pc, 4'd0);
        chk("t1_async_busy", busy, 1'b0);
        cyc();
        rst = 1'b0;
        cyc();
        watch("t1_rerun", 30);
        chk("t1_runs", run_instr.size(), 1);
        chk("t1_run0_instr", run_instr[0], 8'h91);
        chk("t1_run0_len", run_len[0], 2);
        chk("t1_done_idx", done_idx, 4);

        // LDI words, 2 cycles each with a fetch gap, then HALT.
        load(4'd0, 8'h80); load(4'd1, 8'h91); load(4'd2, 8'hA2);
        load(4'd3, 8'hB3); load(4'd4, 8'hFF);
        watch("t2", 40);
        chk("t2_runs", run_instr.size(), 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t2_instr%0d", i), run_instr[i], exp2[i]);
            chk($sformatf("t2_len%0d", i), run_len[i], 2);
            chk($sformatf("t2_pc%0d", i), run_pc[i], i);
        end
        chk("t2_done_idx", done_idx, 13);
        chk("t2_pc_at_done", pc_at_done, 4'd4);

        // Mixed MEM/ALU; slot 0 written in the same cycle as start.
        load(4'd1, 8'h50); load(4'd2, 8'h03); load(4'd3, 8'hFF);
        prog_we = 1'b1; prog_addr = 4'd0; prog_data = 8'h42;
        watch("t3", 40);
        chk("t3_runs", run_instr.size(), 3);
        chk("t3_instr0", run_instr[0], 8'h42);
        chk("t3_len0", run_len[0], 5);
        chk("t3_instr1", run_instr[1], 8'h50);
        chk("t3_len1", run_len[1], 5);
        chk("t3_instr2", run_instr[2], 8'h03);
        chk("t3_len2", run_len[2], 4);
        chk("t3_pc1", run_pc[1], 4'd1);
        chk("t3_pc2", run_pc[2], 4'd2);
        chk("t3_done_idx", done_idx, 18);
        chk("t3_pc_at_done", pc_at_done, 4'd3);

        // Full buffer with no HALT.
        for (int i = 0; i < 16; i++) load(4'(i), 8'h17);
        watch("t4", 120);
        chk("t4_runs", run_instr.size(), 16);
        bad = 0;
        for (int i = 0; i < run_instr.size(); i++) begin
            if (run_len[i] != 4 || run_pc[i] != 4'(i) || run_instr[i] != 8'h17) bad++;
        end
        chk("t4_run_shape", bad, 0);
        chk("t4_done_idx", done_idx, 80);
        chk("t4_pc_at_done", pc_at_done, 4'd15);

        // Write attempt while issuing is dropped and flagged.
        load(4'd0, 8'h80); load(4'd1, 8'h91); load(4'd2, 8'hA2);
        load(4'd3, 8'hB3); load(4'd4, 8'hFF);
        start = 1'b1; cyc(); start = 1'b0;
        wait_valid("t5_valid_wait", 10);
        prog_we = 1'b1; prog_addr = 4'd2; prog_data = 8'hB4;
        cyc();
        prog_we = 1'b0;
        chk("t5_wrerr_pulse", wr_err, 1'b1);
        cyc();
        chk("t5_wrerr_clear", wr_err, 1'b0);
        wait_done("t5_done_wait", 40);
        cyc();
        watch("t5_rerun", 40);
        chk("t5_runs", run_instr.size(), 4);
        chk("t5_slot2", run_instr[2], 8'hA2);

        // Abort mid-issue, then start and abort together in IDLE.
        load(4'd0, 8'h01); load(4'd1, 8'hFF);
        start = 1'b1; cyc(); start = 1'b0;
        wait_valid("t6_valid_wait", 10);
        cyc();
        chk("t6_second_cycle", instr_valid, 1'b1);
        abort = 1'b1; cyc(); abort = 1'b0;
        chk("t6_abort_valid", instr_valid, 1'b0);
        chk("t6_abort_instr", instr_out, 8'hC0);
        chk("t6_abort_pc", pc, 4'd0);
        chk("t6_abort_busy", busy, 1'b0);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            if (done || busy || instr_valid) seen++;
            cyc();
        end
        chk("t6_no_done_after_abort", seen, 0);
        start = 1'b1; abort = 1'b1; cyc(); start = 1'b0; abort = 1'b0;
        chk("t6_start_abort_busy", busy, 1'b0);
        cyc();
        chk("t6_start_abort_busy2", busy, 1'b0);
        chk("t6_start_abort_valid", instr_valid, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
